// File: rtl/wb_axil_pkg.sv
// Shared types and constants for the Wishbone to AXI4-Lite master bridge.
// State encoding, AXI response codes and the default protection value.
package wb_axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R,
    DONE
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  function automatic logic resp_is_err(input logic [1:0] r);
    return (r != RESP_OKAY) && (r != RESP_EXOKAY);
  endfunction

endpackage

// File: rtl/wb_axil_master_bridge.sv
// Pipelined Wishbone slave to AXI4-Lite master, one transaction in flight.
// Optional response timeout enabled by defining WB_AXIL_TIMEOUT_EN.
module wb_axil_master_bridge
  import wb_axil_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    m_axi_aclk,
  input  logic                    m_axi_aresetn,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   wb_addr_i,
  input  logic [DATA_WIDTH-1:0]   wb_data_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  output logic                    wb_stall_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic [DATA_WIDTH-1:0]   wb_data_o,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int SW = DATA_WIDTH / 8;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [SW-1:0]         strb_q;

  logic awvalid_q, wvalid_q, arvalid_q;
  logic bready_q, rready_q;
  logic ack_q, err_q, abort_q;

  logic accept;
  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic aw_ok, w_ok;
  logic resp_err;
  logic tmo_hit, tmo_fire;

  assign accept   = (state_q == IDLE) && wb_cyc_i && wb_stb_i;
  assign aw_hs    = awvalid_q && m_axi_awready;
  assign w_hs     = wvalid_q && m_axi_wready;
  assign ar_hs    = arvalid_q && m_axi_arready;
  assign b_hs     = bready_q && m_axi_bvalid;
  assign r_hs     = rready_q && m_axi_rvalid;
  assign aw_ok    = !awvalid_q || m_axi_awready;
  assign w_ok     = !wvalid_q || m_axi_wready;
  assign resp_err = (state_q == WR_B) ? resp_is_err(m_axi_bresp)
                                      : resp_is_err(m_axi_rresp);

`ifdef WB_AXIL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] tmo_q;
  logic          busy;

  assign busy    = (state_q != IDLE) && (state_q != DONE);
  assign tmo_hit = busy && (tmo_q == CW'(TIMEOUT_CYCLES - 1));

  // Wait counter, restarted on every state change.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      tmo_q <= '0;
    end else if (!busy || state_d != state_q) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state logic; progress wins over a same-cycle timeout.
  always_comb begin
    state_d  = state_q;
    tmo_fire = 1'b0;
    unique case (state_q)
      IDLE:    if (accept) state_d = wb_we_i ? WR_AW_W : RD_AR;
      WR_AW_W: if (aw_ok && w_ok) state_d = WR_B;
      WR_B:    if (b_hs) state_d = DONE;
      RD_AR:   if (ar_hs) state_d = RD_R;
      RD_R:    if (r_hs) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (tmo_hit && state_d == state_q) begin
      state_d  = IDLE;
      tmo_fire = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // Request capture, AXI handshake flags and Wishbone completion.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      rdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (accept) begin
        addr_q    <= wb_addr_i;
        wdata_q   <= wb_data_i;
        strb_q    <= wb_sel_i;
        awvalid_q <= wb_we_i;
        wvalid_q  <= wb_we_i;
        arvalid_q <= !wb_we_i;
        abort_q   <= 1'b0;
      end else if (state_q != IDLE && !wb_cyc_i) begin
        abort_q <= 1'b1;
      end
      if (aw_hs) awvalid_q <= 1'b0;
      if (w_hs)  wvalid_q  <= 1'b0;
      if (state_q == WR_AW_W && state_d == WR_B) bready_q <= 1'b1;
      if (b_hs) bready_q <= 1'b0;
      if (ar_hs) begin
        arvalid_q <= 1'b0;
        rready_q  <= 1'b1;
      end
      if (r_hs) begin
        rready_q <= 1'b0;
        rdata_q  <= m_axi_rdata;
      end
      if (state_d == DONE && wb_cyc_i && !abort_q) begin
        ack_q <= !resp_err;
        err_q <= resp_err;
      end
      if (tmo_fire) begin
        awvalid_q <= 1'b0;
        wvalid_q  <= 1'b0;
        arvalid_q <= 1'b0;
        bready_q  <= 1'b0;
        rready_q  <= 1'b0;
        err_q     <= wb_cyc_i && !abort_q;
      end
    end
  end

  assign wb_stall_o    = (state_q != IDLE);
  assign wb_ack_o      = ack_q;
  assign wb_err_o      = err_q;
  assign wb_data_o     = rdata_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = PROT_DEFAULT;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = strb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = PROT_DEFAULT;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_wb_axil_master_bridge.sv
// Directed bench for wb_axil_master_bridge: vector table plus corner cases.
// Timeout sequence is compiled in when WB_AXIL_TIMEOUT_EN is defined.
module tb_wb_axil_master_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdat = '0;
  logic [3:0]  sel = '0;
  logic        stall, ack, err;
  logic [31:0] rdat_o;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, arvalid, bready, rready;
  logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
  logic        bvalid = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic [31:0] rdata = '0;

  always #5 clk = ~clk;

  wb_axil_master_bridge #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_addr_i(addr), .wb_data_i(wdat), .wb_sel_i(sel),
    .wb_stall_o(stall), .wb_ack_o(ack), .wb_err_o(err),
    .wb_data_o(rdat_o),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    int          aw_d, w_d, ar_d, b_d, r_d;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          lat;
    logic        ack, err;
    int          n_aw, n_w, n_ar;
  } vec_t;

  vec_t vt[8];
  int   n_tests = 0;
  int   n_fail = 0;

  function automatic vec_t mk(
    input logic we_, input logic [31:0] a, input logic [31:0] d,
    input logic [3:0] s, input int awd, input int wd, input int ard,
    input int bd, input int rd, input logic [1:0] rsp,
    input logic [31:0] rdv, input int lat, input logic ak,
    input logic er, input int naw, input int nw, input int nar);
    vec_t v;
    v.we = we_; v.addr = a; v.data = d; v.sel = s;
    v.aw_d = awd; v.w_d = wd; v.ar_d = ard; v.b_d = bd; v.r_d = rd;
    v.resp = rsp; v.rdata = rdv; v.lat = lat; v.ack = ak; v.err = er;
    v.n_aw = naw; v.n_w = nw; v.n_ar = nar;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_quiet();
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int aw_s = 0, w_s = 0, ar_s = 0, b_s = 0, r_s = 0, lat = 0;
    logic done = 0, g_ack = 0, g_err = 0, ord_bad = 0, st_bad = 0;
    logic [31:0] c_awa = '0, c_wd = '0, c_ara = '0, c_rd = '0;
    logic [3:0]  c_st = '0;
    chk({tag, ".stall_idle"}, stall, 0);
    cyc = 1; stb = 1; we = v.we; addr = v.addr; wdat = v.data; sel = v.sel;
    step();
    stb = 0;
    for (int n = 1; n <= 60 && !done; n++) begin
      if (!stall) st_bad = 1;
      if (bready && (awvalid || wvalid)) ord_bad = 1;
      if (ack || err) begin
        g_ack = ack; g_err = err; c_rd = rdat_o; lat = n; done = 1;
      end
      if (awvalid && aw_s == 0) c_awa = awaddr;
      if (wvalid && w_s == 0) begin c_wd = wdata; c_st = wstrb; end
      if (arvalid && ar_s == 0) c_ara = araddr;
      awready = awvalid && (aw_s >= v.aw_d);
      wready  = wvalid && (w_s >= v.w_d);
      arready = arvalid && (ar_s >= v.ar_d);
      bvalid  = bready && (b_s >= v.b_d);
      rvalid  = rready && (r_s >= v.r_d);
      bresp = v.resp; rresp = v.resp; rdata = v.rdata;
      if (awvalid) aw_s++;
      if (wvalid) w_s++;
      if (arvalid) ar_s++;
      if (bready) b_s++;
      if (rready) r_s++;
      if (done) axi_quiet();
      step();
    end
    chk({tag, ".completed"}, done, 1);
    chk({tag, ".latency"}, lat, v.lat);
    chk({tag, ".ack"}, g_ack, v.ack);
    chk({tag, ".err"}, g_err, v.err);
    chk({tag, ".aw_cycles"}, aw_s, v.n_aw);
    chk({tag, ".w_cycles"}, w_s, v.n_w);
    chk({tag, ".ar_cycles"}, ar_s, v.n_ar);
    chk({tag, ".bready_order"}, ord_bad, 0);
    chk({tag, ".stall_busy"}, st_bad, 0);
    if (v.we) begin
      chk({tag, ".awaddr"}, c_awa, v.addr);
      chk({tag, ".wdata"}, c_wd, v.data);
      chk({tag, ".wstrb"}, c_st, v.sel);
    end else begin
      chk({tag, ".araddr"}, c_ara, v.addr);
      if (v.ack) chk({tag, ".rdata"}, c_rd, v.rdata);
    end
    chk({tag, ".ack_pulse"}, ack, 0);
    chk({tag, ".err_pulse"}, err, 0);
    chk({tag, ".stall_after"}, stall, 0);
  endtask

  initial begin
    vt[0] = mk(1, 32'h10, 32'hDEADBEEF, 4'b0011, 0, 0, 0, 0, 0,
               2'b00, 32'h0, 3, 1, 0, 1, 1, 0);
    vt[1] = mk(1, 32'h14, 32'hCAFEF00D, 4'b1111, 4, 0, 0, 0, 0,
               2'b00, 32'h0, 7, 1, 0, 5, 1, 0);
    vt[2] = mk(1, 32'h18, 32'h01020304, 4'b1100, 0, 3, 0, 0, 0,
               2'b00, 32'h0, 6, 1, 0, 1, 4, 0);
    vt[3] = mk(1, 32'h1C, 32'h00000000, 4'b0001, 0, 0, 0, 1, 0,
               2'b10, 32'h0, 4, 0, 1, 1, 1, 0);
    vt[4] = mk(1, 32'h24, 32'hFFFFFFFF, 4'b1010, 0, 0, 0, 0, 0,
               2'b01, 32'h0, 3, 1, 0, 1, 1, 0);
    vt[5] = mk(0, 32'h20, 32'h0, 4'b1111, 0, 0, 0, 0, 2,
               2'b00, 32'h12345678, 5, 1, 0, 0, 0, 1);
    vt[6] = mk(0, 32'h28, 32'h0, 4'b1111, 0, 0, 0, 0, 0,
               2'b11, 32'hBAD0BAD0, 3, 0, 1, 0, 0, 1);
    vt[7] = mk(0, 32'h2C, 32'h0, 4'b1111, 0, 0, 3, 0, 0,
               2'b00, 32'hA5A55A5A, 6, 1, 0, 0, 0, 4);

    #12;
    chk("rst.awvalid", awvalid, 0);
    chk("rst.wvalid", wvalid, 0);
    chk("rst.arvalid", arvalid, 0);
    chk("rst.bready", bready, 0);
    chk("rst.rready", rready, 0);
    chk("rst.ack", ack, 0);
    chk("rst.err", err, 0);
    chk("rst.data_o", rdat_o, 0);
    chk("rst.awaddr", awaddr, 0);
    chk("rst.stall", stall, 0);
    chk("rst.prot", {awprot, arprot}, 0);
    step();
    rst_n = 1;
    step();

    for (int i = 0; i < 8; i++) run_txn(vt[i], $sformatf("vec%0d", i));

    // Reset asserted while a write address is pending.
    begin
      logic seen = 0;
      cyc = 1; stb = 1; we = 1; addr = 32'h30; wdat = 32'h55; sel = 4'hF;
      step();
      stb = 0;
      chk("arst.pre_awvalid", awvalid, 1);
      rst_n = 0;
      #1;
      chk("arst.awvalid", awvalid, 0);
      chk("arst.wvalid", wvalid, 0);
      chk("arst.stall", stall, 0);
      for (int k = 0; k < 3; k++) begin
        if (ack || err) seen = 1;
        step();
      end
      rst_n = 1;
      cyc = 0;
      step();
      chk("arst.no_completion", seen, 0);
      run_txn(vt[0], "post_rst");
    end

    // Master drops cyc mid-read: AXI finishes, no Wishbone completion.
    begin
      logic seen = 0, r_done = 0;
      cyc = 1; stb = 1; we = 0; addr = 32'h40;
      step();
      stb = 0; cyc = 0;
      for (int k = 0; k < 10; k++) begin
        if (ack || err) seen = 1;
        if (rready) r_done = 1;
        arready = arvalid;
        rvalid = rready; rresp = 2'b00; rdata = 32'h77;
        step();
      end
      axi_quiet();
      chk("abort.no_ack", seen, 0);
      chk("abort.r_done", r_done, 1);
      chk("abort.stall", stall, 0);
    end

`ifdef WB_AXIL_TIMEOUT_EN
    // Slave never answers B: error pulse 16 cycles after entering WR_B.
    begin
      int ecyc = -1;
      cyc = 1; stb = 1; we = 1; addr = 32'h50; wdat = 32'h1; sel = 4'hF;
      step();
      stb = 0;
      awready = 1; wready = 1;
      step();
      axi_quiet();
      chk("tmo.bready", bready, 1);
      for (int k = 0; k < 40 && ecyc < 0; k++) begin
        if (err) ecyc = k;
        else step();
      end
      chk("tmo.err_cycle", ecyc, 16);
      chk("tmo.idle", stall, 0);
      chk("tmo.bready_drop", bready, 0);
      bvalid = 1;
      step();
      chk("tmo.late_ack", ack, 0);
      chk("tmo.late_err", err, 0);
      chk("tmo.late_bready", bready, 0);
      bvalid = 0;
      cyc = 0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
